// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: sequences each instruction and drives
// all datapath enables, mux selects, ALU control and PC enable. Optional: MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_rdy;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_bne;
  logic [1:0] w_aluop;

  assign w_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state = r_state;
  assign pcen  = w_pcwrite | (w_branch & zero) | (w_bne & ~zero);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    w_aluop   = 2'b00;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_bne     = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = w_rdy;
        w_pcwrite = w_rdy;
        w_next    = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_BNE:       w_next = S_BNEEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      // The write strobe stays up for the whole wait so the memory sees a stable request.
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        w_next   = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = (r_state == S_BEQEX);
        w_bne    = (r_state == S_BNEEX);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        illegal = 1'b1;
        w_next  = S_TRAP;
`else
        w_next  = S_FETCH;
`endif
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (w_aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed test-plan scenarios plus randomized instruction streams,
// all checked every cycle against an instruction-path reference model.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_state = 0;
  int m_path[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal), .state(state)
  );

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for a state: zero except what the state's row lists.
  function automatic outs_t model_out(input int st, input logic [5:0] f, input logic z, input logic rdy);
    outs_t e;
    e = '0;
    e.alucontrol = 3'b010;
    e.state = st[3:0];
    case (st)
      0:  begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcen = rdy; end
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3:  e.iord = 1'b1;
      4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
      6:  begin e.alusrca = 1'b1; e.alucontrol = rtype_alu(f); end
      7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8:  begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.pcen = z; end
      12: begin e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.pcen = ~z; end
      9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1'b1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      13: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Model: each opcode owns a list of post-decode states; FETCH/MEMRD/MEMWR repeat while not ready.
  task automatic load_path(input logic [5:0] o);
    m_path.delete();
    case (o)
      OP_LW:   m_path = '{2, 3, 4};
      OP_SW:   m_path = '{2, 5};
      OP_R:    m_path = '{6, 7};
      OP_BEQ:  m_path = '{8};
      OP_BNE:  m_path = '{12};
      OP_ADDI: m_path = '{9, 10};
      OP_J:    m_path = '{11};
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      default: m_path = '{13};
`else
      default: ;
`endif
    endcase
  endtask

  task automatic model_step(input logic rst, input logic [5:0] o, input logic rdy);
    if (!rst) begin
      m_state = 0;
      m_path.delete();
    end else if (m_state == 13) begin
      m_state = 13;
    end else if (m_state == 0) begin
      if (rdy) m_state = 1;
    end else if ((m_state == 3 || m_state == 5) && !rdy) begin
      m_state = m_state;
    end else begin
      if (m_state == 1) load_path(o);
      m_state = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
  endtask

  task automatic cycle(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy);
    outs_t got, exp;
    @(negedge clk);
    reset = rst; op = o; funct = f; zero = z; mem_ready = rdy;
    #1;
    got = {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb,
           pcsrc, alucontrol, pcen, illegal, state};
    exp = model_out(m_state, f, z, rdy);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model cyc=%0d: got=%h want=%h (state got=%0d want=%0d)",
               cyc, got, exp, state, m_state);
    end
    model_step(rst, o, rdy);
    cyc++;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d: got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic branch_test(input logic [5:0] o, input logic z, input int want_st, input int want_pcen);
    cycle(1'b1, o, 6'h0, z, 1'b1);
    cycle(1'b1, o, 6'h0, z, 1'b1);
    cycle(1'b1, o, 6'h0, z, 1'b1);
    chk("br_state", state, want_st);
    chk("br_pcen", pcen, want_pcen);
    chk("br_pcsrc", pcsrc, 1);
    cycle(1'b1, o, 6'h0, z, 1'b0);
    chk("br_back", state, 0);
  endtask

  initial begin
    int lw_st[6];
    logic [5:0] cur_op, cur_f;
    logic rst, rdy;
    int trap_cnt;
    lw_st = '{0, 1, 2, 3, 4, 0};

    cycle(1'b0, OP_R, 6'h0, 1'b0, 1'b1);
    chk("rst_state", state, 0);
    chk("rst_illegal", illegal, 0);

    // lw, stalling only at the trailing FETCH so the next sequence starts clean
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, OP_LW, 6'h0, 1'b0, (i == 5) ? 1'b0 : 1'b1);
      chk("lw_state", state, lw_st[i]);
      if (i == 4) begin
        chk("lw_regwrite", regwrite, 1);
        chk("lw_memtoreg", memtoreg, 1);
      end
    end

    for (int i = 0; i < 3; i++) cycle(1'b1, OP_SW, 6'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, OP_SW, 6'h0, 1'b0, (i == 3) ? 1'b1 : 1'b0);
      chk("sw_state", state, 5);
      chk("sw_memwrite", memwrite, 1);
    end
    cycle(1'b1, OP_SW, 6'h0, 1'b0, 1'b0);
    chk("sw_done", state, 0);

    cycle(1'b1, OP_R, 6'h2a, 1'b0, 1'b1);
    cycle(1'b1, OP_R, 6'h2a, 1'b0, 1'b1);
    cycle(1'b1, OP_R, 6'h2a, 1'b0, 1'b1);
    chk("slt_state", state, 6);
    chk("slt_alu", alucontrol, 7);
    cycle(1'b1, OP_R, 6'h2a, 1'b0, 1'b1);
    chk("rwb_regdst", regdst, 1);
    chk("rwb_regwrite", regwrite, 1);
    cycle(1'b1, OP_R, 6'h2a, 1'b0, 1'b0);
    chk("r_done", state, 0);

    branch_test(OP_BEQ, 1'b1, 8, 1);
    branch_test(OP_BEQ, 1'b0, 8, 0);
    branch_test(OP_BNE, 1'b0, 12, 1);
    branch_test(OP_BNE, 1'b1, 12, 0);

    cycle(1'b1, OP_BAD, 6'h0, 1'b0, 1'b1);
    cycle(1'b1, OP_BAD, 6'h0, 1'b0, 1'b1);
    chk("bad_decode", state, 1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, OP_BAD, 6'h0, 1'b0, 1'b1);
      chk("trap_state", state, 13);
      chk("trap_illegal", illegal, 1);
      chk("trap_pcen", pcen, 0);
    end
    cycle(1'b0, OP_BAD, 6'h0, 1'b0, 1'b0);
`endif
    cycle(1'b1, OP_BAD, 6'h0, 1'b0, 1'b0);
    chk("bad_back", state, 0);
    chk("bad_illegal", illegal, 0);

    for (int i = 0; i < 3; i++) cycle(1'b1, OP_LW, 6'h0, 1'b0, 1'b1);
    cycle(1'b0, OP_LW, 6'h0, 1'b0, 1'b1);
    chk("rmid_memrd", state, 3);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, OP_LW, 6'h0, 1'b0, 1'b0);
      chk("rmid_state", state, 0);
      chk("rmid_regwrite", regwrite, 0);
    end

    cur_op = OP_R;
    cur_f = 6'h20;
    trap_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(99) != 0);
      if (m_state == 13) trap_cnt++;
      if (trap_cnt > 4) begin
        rst = 1'b0;
        trap_cnt = 0;
      end
      if (m_state == 0) begin
        case ($urandom_range(8))
          0: cur_op = OP_LW;
          1: cur_op = OP_SW;
          2: cur_op = OP_BEQ;
          3: cur_op = OP_BNE;
          4: cur_op = OP_ADDI;
          5: cur_op = OP_J;
          6: cur_op = 6'($urandom_range(63));
          default: cur_op = OP_R;
        endcase
        case ($urandom_range(5))
          0: cur_f = 6'h20;
          1: cur_f = 6'h22;
          2: cur_f = 6'h24;
          3: cur_f = 6'h25;
          4: cur_f = 6'h2a;
          default: cur_f = 6'($urandom_range(63));
        endcase
      end
      rdy = ($urandom_range(3) != 0);
      cycle(rst, cur_op, cur_f, 1'($urandom_range(1)), rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multicycle MIPS datapath. It replaces the single-cycle decoder by sequencing one instruction over 3-5 states.
- Drives all datapath enables and mux selects. Decodes ALU control from op/funct and computes the PC-enable, including beq/bne.
- Stalls on a memory ready handshake in memory-access states.
- Sits between the instruction register's op/funct fields and the shared instruction/data memory datapath.

Parameters:
- MEM_HANDSHAKE, 1, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge forces FETCH
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write strobe
- memtoreg  out  1  writeback data: 1 = memory data, 0 = ALUOut
- regdst  out  1  destination register: 1 = rd, 0 = rt
- regwrite  out  1  register file write
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- pcen  out  1  PC register enable
- illegal  out  1  illegal-opcode flag
- state  out  4  current state code (debug and verification)

Behaviour:
- Reset: state = FETCH (0). All outputs come from the FETCH decode, which is combinational from state, op, funct, zero and mem_ready. illegal = 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12, TRAP 13. Codes 14-15 go to FETCH on the next cycle.
- Any output not listed for a state is 0. aluop is internal.
- FETCH: alusrcb = 01, aluop = 00, pcsrc = 00. irwrite = pcwrite = rdy. If rdy, go to DECODE; otherwise stay.
- rdy = mem_ready when MEM_HANDSHAKE = 1; otherwise rdy = 1.
- DECODE: alusrcb = 11, aluop = 00. Next state by op:
  - 100011 / 101011: MEMADR
  - 000000: RTYPEEX
  - 000100: BEQEX
  - 000101: BNEEX
  - 001000: ADDIEX
  - 000010: JEX
  - any other op: see Optional Feature
- MEMADR: alusrca = 1, alusrcb = 10. Go to MEMRD if op = 100011, else MEMWR.
- MEMRD: iord = 1. Stay until rdy, then MEMWB.
- MEMWB: memtoreg = 1, regwrite = 1. Then FETCH.
- MEMWR: iord = 1, memwrite = 1, held every cycle while waiting. On rdy, go to FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 10. Then RTYPEWB.
- RTYPEWB: regdst = 1, regwrite = 1. Then FETCH.
- BEQEX / BNEEX: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01. Internal branch = 1 (BEQEX) or bne = 1 (BNEEX). Then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10. Then ADDIWB.
- ADDIWB: regwrite = 1. Then FETCH.
- JEX: pcsrc = 10, pcwrite = 1. Then FETCH.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). It is combinational, in the same cycle.
- ALU decode:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 000.
  - aluop 11 -> 000.
- Reset mid-instruction: abandons the instruction. Next state = FETCH; no pending regwrite or memwrite is issued after the reset edge.
- Latency in cycles with rdy always 1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each wait cycle adds 1 in FETCH, MEMRD or MEMWR.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP.
  - TRAP drives all enables to 0 and illegal = 1.
  - TRAP stays until reset; pcen = 0.
- Undefined: an unknown op in DECODE returns to FETCH (executes as NOP). TRAP is unreachable and illegal is tied to 0.

Test Plan:
- Reset, then lw (op 100011) with mem_ready = 1 -> state sequence 0,1,2,3,4,0. In state 4, regwrite = 1 and memtoreg = 1.
- sw (op 101011) with mem_ready low for 3 cycles in MEMWR -> memwrite = 1 for 4 consecutive cycles, then state 0.
- R-type funct 101010 -> in RTYPEEX, alucontrol = 111. In RTYPEWB, regdst = 1 and regwrite = 1.
- beq with zero = 1 -> pcen = 1 and pcsrc = 01 in state 8. Same with zero = 0 -> pcen = 0. bne mirrors this: zero = 0 -> pcen = 1.
- op 111111 -> with the macro: state 13, illegal = 1, held for 10 cycles until reset. Without the macro: state returns to 0 after DECODE.
- reset = 0 asserted in MEMRD -> next cycle state = 0. No regwrite in that cycle or the following one.
